// File: rtl/c2c_cntr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : c2c_cntr_pkg
// Description : Shared constants and types for the C2C control-port
//               AXI4-Lite register file (register count, address decode
//               field position, response code, word/index types).
// Revision    : 1.0 - initial release
// ============================================================================
package c2c_cntr_pkg;

    localparam int NUM_REGS    = 4;
    localparam int REG_IDX_LSB = 2;
    localparam int REG_IDX_W   = 2;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [31:0]          reg_word_t;

endpackage : c2c_cntr_pkg
`default_nettype wire

// File: rtl/c2c_cntr_axil_regs.sv
`default_nettype none
// ============================================================================
// Module      : c2c_cntr_axil_regs
// Description : AXI4-Lite slave terminating the C2C control port. Holds four
//               32-bit control words driven out to the Aurora MAC datapath and
//               pulses reg_wr_pulse[i] for one cycle after register i is
//               written. One outstanding write and one outstanding read, each
//               handled independently.
// Ports       : S_AXI_ACLK / S_AXI_ARESETN - clock, async active-low reset
//               S_AXI_AW* / S_AXI_W* / S_AXI_B* - write address/data/response
//               S_AXI_AR* / S_AXI_R*          - read address/data
//               ctrl_regs    - register i at bits [32i+31:32i]
//               reg_wr_pulse - one-cycle strobe per written register
// Revision    : 1.0 - initial release
// ============================================================================
module c2c_cntr_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [32*NUM_REGS-1:0]          ctrl_regs,
    output logic [NUM_REGS-1:0]             reg_wr_pulse
);

    import c2c_cntr_pkg::*;

    localparam int c_NUM_LANES = C_S_AXI_DATA_WIDTH / 8;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    reg_word_t                          r_regs [NUM_REGS];
    logic                               r_awready;
    logic                               r_wready;
    logic                               r_arready;
    logic                               r_aw_held;
    logic                               r_w_held;
    reg_idx_t                           r_aw_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]      r_wdata;
    logic [c_NUM_LANES-1:0]             r_wstrb;
    logic                               r_bvalid;
    logic                               r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0]      r_rdata;
    logic [NUM_REGS-1:0]                r_wr_pulse;

    // ------------------------------------------------------------------
    // Handshakes and write alignment
    // ------------------------------------------------------------------
    logic                               w_aw_hs;
    logic                               w_w_hs;
    logic                               w_ar_hs;
    logic                               w_commit;
    reg_idx_t                           w_wr_idx;
    reg_idx_t                           w_rd_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]      w_wr_data;
    logic [c_NUM_LANES-1:0]             w_wr_strb;
    logic                               w_aw_held_nxt;
    logic                               w_w_held_nxt;
    logic                               w_bvalid_nxt;
    logic                               w_rvalid_nxt;

    assign w_aw_hs  = S_AXI_AWVALID && r_awready;
    assign w_w_hs   = S_AXI_WVALID  && r_wready;
    assign w_ar_hs  = S_AXI_ARVALID && r_arready;

    // A write commits as soon as both halves are present, whether each was
    // captured earlier or is handshaking on this very edge.
    assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    // Prefer the captured copy; otherwise take the live bus value.
    assign w_wr_idx  = r_aw_held ? r_aw_idx : S_AXI_AWADDR[REG_IDX_LSB +: REG_IDX_W];
    assign w_wr_data = r_w_held  ? r_wdata  : S_AXI_WDATA;
    assign w_wr_strb = r_w_held  ? r_wstrb  : S_AXI_WSTRB;
    assign w_rd_idx  = S_AXI_ARADDR[REG_IDX_LSB +: REG_IDX_W];

    // Next-state of the flags that gate the READY outputs. The READYs are
    // registered from these so no input reaches a READY combinationally.
    always_comb begin
        w_aw_held_nxt = r_aw_held;
        w_w_held_nxt  = r_w_held;
        w_bvalid_nxt  = r_bvalid;
        w_rvalid_nxt  = r_rvalid;

        if (r_bvalid && S_AXI_BREADY) begin
            w_bvalid_nxt = 1'b0;
        end

        if (w_commit) begin
            w_aw_held_nxt = 1'b0;
            w_w_held_nxt  = 1'b0;
            w_bvalid_nxt  = 1'b1;
        end else begin
            if (w_aw_hs) begin
                w_aw_held_nxt = 1'b1;
            end
            if (w_w_hs) begin
                w_w_held_nxt = 1'b1;
            end
        end

        if (w_ar_hs) begin
            w_rvalid_nxt = 1'b1;
        end else if (r_rvalid && S_AXI_RREADY) begin
            w_rvalid_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_aw_idx   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_wr_pulse <= '0;
        end else begin
            r_aw_held <= w_aw_held_nxt;
            r_w_held  <= w_w_held_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_awready <= !w_aw_held_nxt && !w_bvalid_nxt;
            r_wready  <= !w_w_held_nxt  && !w_bvalid_nxt;

            if (w_aw_hs && !w_commit) begin
                r_aw_idx <= S_AXI_AWADDR[REG_IDX_LSB +: REG_IDX_W];
            end
            if (w_w_hs && !w_commit) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end

            r_wr_pulse <= '0;
            if (w_commit) begin
                r_wr_pulse[w_wr_idx] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register array with per-byte-lane update
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            for (int k = 0; k < c_NUM_LANES; k++) begin
                if (w_wr_strb[k]) begin
                    r_regs[w_wr_idx][8*k +: 8] <= w_wr_data[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel. RDATA samples the array before any same-edge write
    // lands, so a colliding read returns the old value.
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_arready <= 1'b0;
        end else begin
            r_rvalid  <= w_rvalid_nxt;
            r_arready <= !w_rvalid_nxt;
            if (w_ar_hs) begin
                r_rdata <= r_regs[w_rd_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = AXI_RESP_OKAY;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = AXI_RESP_OKAY;
    assign reg_wr_pulse  = r_wr_pulse;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_ctrl_regs
        assign ctrl_regs[32*gi +: 32] = r_regs[gi];
    end

    // Protection bits and the byte offset within a word carry no meaning here.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[REG_IDX_LSB-1:0], S_AXI_ARADDR[REG_IDX_LSB-1:0]};

endmodule : c2c_cntr_axil_regs
`default_nettype wire

// File: doc/c2c_cntr_axil_regs.md
Name: c2c_cntr_axil_regs

Overview:
AXI4-Lite slave register file that terminates the control port of the chip-to-chip (C2C) control interface. It is the responder end of the link that the master VIP drives in simulation.
- Holds four 32-bit read/write control words and exposes them to the Aurora MAC datapath.
- Emits a one-cycle update pulse per register whenever that register is written.
- Supports one outstanding write and one outstanding read, handled independently.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; decode uses ADDR[3:2].
NUM_REGS, 4, number of registers; fixed at 4.

Ports:
S_AXI_ACLK  in  1  single clock for all logic
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  4  write byte address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response; always 2'b00 (OKAY)
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  4  read byte address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response; always 2'b00
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
ctrl_regs  out  128  register contents; reg i occupies bits [32i+31:32i]
reg_wr_pulse  out  4  one-cycle pulse per written register

Behaviour:
- Reset: one clock S_AXI_ACLK; asynchronous active-low reset S_AXI_ARESETN.
  - While S_AXI_ARESETN=0, every output is 0: all READY/VALID, BRESP, RDATA, RRESP, ctrl_regs, reg_wr_pulse.
  - AWREADY, WREADY and ARREADY rise on the first rising edge after reset release.
- Write channel: each of AW and W has a 1-entry holding register with a "held" flag.
  - AWREADY = !aw_held && !BVALID (registered). WREADY = !w_held && !BVALID (registered).
  - AW and W are accepted in either order, or on the same edge.
- Write commit: occurs on the edge where both an address and data are available, each either already held or handshaking on that edge. On that edge:
  - The selected register updates per byte lane; lane k is written only if WSTRB[k]=1.
  - BVALID is set.
  - reg_wr_pulse[ADDR[3:2]] is high for exactly the following cycle.
  - Both held flags clear.
- Write response: BVALID holds until BVALID&&BREADY. AWREADY and WREADY stay low until the edge after the B handshake.
- Write latency: AW and W on edge t give ctrl_regs updated and BVALID=1 after edge t. If W arrives at t+n, the commit is at t+n.
- Read channel:
  - ARREADY = !RVALID (registered).
  - On AR handshake at edge t: RDATA = reg[ARADDR[3:2]] and RVALID=1 after edge t.
  - RDATA/RVALID are held stable until RVALID&&RREADY. ARREADY returns on the following edge.
- Decode: ADDR[1:0] is ignored, so unaligned addresses alias to the word. Every address maps to a register; no SLVERR.
- Read/write to the same register on the same edge: the read returns the pre-write value.
- Mid-transaction reset: held AW/W are discarded, BVALID and RVALID drop immediately, and registers clear.
- No combinational path from any input to any READY output.

Decomposition:
- Package c2c_cntr_pkg holds:
  - NUM_REGS = 4
  - REG_IDX_LSB = 2, REG_IDX_W = 2
  - AXI_RESP_OKAY = 2'b00
  - typedef reg_idx_t (logic [1:0])
  - typedef reg_word_t (logic [31:0])
- No sub-module; write-align, read and register-array logic live in one module of roughly 180 lines.

Test Plan:
- Sequential fill: write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read all four -> RDATA 0x1, 0x2, 0x3, 0x4; every BRESP and RRESP is 0. ctrl_regs = 0x00000004_00000003_00000002_00000001.
- W before AW: WVALID with 0xDEADBEEF at cycle 0, AWVALID to 0x4 at cycle 3 -> WREADY drops after cycle 0, commit on the AW edge, BVALID the next cycle, reg_wr_pulse = 4'b0010 for one cycle, reg1 = 0xDEADBEEF.
- Byte strobe: reg1 = 0x00000002, then write 0xAABBCCDD with WSTRB 4'b0010 -> reg1 reads 0x0000CC02.
- Back-pressure: BREADY low for 5 cycles after a write -> BVALID held and AWREADY/WREADY low throughout. A second AW presented during this window is accepted only on the edge after the B handshake.
- Collision: reg2 = 0x11111111; AR to 0x8 and AW/W of 0x22222222 to 0x8 on the same edge -> RDATA 0x11111111, then a subsequent read returns 0x22222222.
- Reset mid-write: AW accepted, W pending, ARESETN pulsed low -> all outputs 0 asynchronously. After release, a W alone produces no commit and BVALID stays 0; ctrl_regs = 0.
